// File: rtl/sha3_pkg.sv
// Shared SHA-3 constants and loader state encoding.
// Used by the SHAKE256 message loader.
package sha3_pkg;

    localparam int WORD_W        = 64;
    localparam int RATE_BITS     = 1088;
    localparam int RATE_WORDS    = 17;
    localparam int MAX_MSG_BYTES = 135;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_EMIT   = 2'd1,
        ST_ERR    = 2'd2,
        ST_DRAIN  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/shake256_msg_loader.sv
// Packs a byte-aligned 64-bit stream into one SHAKE256 rate block.
// Single-block messages only; oversize messages are dropped with err.
module shake256_msg_loader
    import sha3_pkg::*;
#(
    parameter int WORD_W    = 64,
    parameter int RATE_BITS = 1088,
    parameter int MAX_BYTES = 135
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WORD_W-1:0]    s_data,
    input  logic                 s_last,
    input  logic [3:0]           s_bytes,
    output logic                 out_en,
    output logic [RATE_BITS-1:0] out_data,
    output logic [10:0]          out_len,
    output logic [3:0]           out_block_num,
    output logic                 err,
    output logic                 busy
);

    localparam logic [7:0] MAX_B8 = 8'(MAX_BYTES);

    loader_state_e     state_q, state_d;
    logic [4:0]        wcnt_q, wcnt_d;
    logic [7:0]        bcnt_q, bcnt_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] buf_q [RATE_WORDS];
    logic [WORD_W-1:0] buf_d [RATE_WORDS];

    logic              hs;
    logic [3:0]        beat_bytes;
    logic [7:0]        total;
    logic [WORD_W-1:0] beat_word;

    // Keeps the first n bytes (MSB side) of a last beat.
    function automatic logic [WORD_W-1:0] byte_mask(input logic [3:0] n);
        case (n)
            4'd0:    byte_mask = 64'h0000_0000_0000_0000;
            4'd1:    byte_mask = 64'hFF00_0000_0000_0000;
            4'd2:    byte_mask = 64'hFFFF_0000_0000_0000;
            4'd3:    byte_mask = 64'hFFFF_FF00_0000_0000;
            4'd4:    byte_mask = 64'hFFFF_FFFF_0000_0000;
            4'd5:    byte_mask = 64'hFFFF_FFFF_FF00_0000;
            4'd6:    byte_mask = 64'hFFFF_FFFF_FFFF_0000;
            4'd7:    byte_mask = 64'hFFFF_FFFF_FFFF_FF00;
            default: byte_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    assign s_ready = (state_q == ST_ACCEPT) || (state_q == ST_DRAIN);
    assign hs      = s_valid && s_ready;

    assign beat_bytes = s_last ? s_bytes : 4'd8;
    assign total      = bcnt_q + {4'b0000, beat_bytes};
    assign beat_word  = s_last ? (s_data & byte_mask(s_bytes)) : s_data;

    // Next-state, counter and buffer update logic.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        buf_d   = buf_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_ACCEPT: begin
                if (hs) begin
                    if (!s_last && (wcnt_q == 5'd16)) begin
                        state_d = ST_DRAIN;
                        err_d   = 1'b1;
                    end else begin
                        for (int k = 0; k < RATE_WORDS; k++) begin
                            if (wcnt_q == 5'(k)) buf_d[k] = beat_word;
                        end
                        wcnt_d = wcnt_q + 5'd1;
                        bcnt_d = total;
                        if (s_last) begin
                            if ((s_bytes > 4'd8) || (total > MAX_B8)) begin
                                state_d = ST_ERR;
                                err_d   = 1'b1;
                            end else begin
                                state_d = ST_EMIT;
                            end
                        end
                    end
                end
            end
            ST_EMIT, ST_ERR: begin
                state_d = ST_ACCEPT;
                wcnt_d  = '0;
                bcnt_d  = '0;
                buf_d   = '{default: '0};
            end
            ST_DRAIN: begin
                if (hs && s_last) begin
                    state_d = ST_ACCEPT;
                    wcnt_d  = '0;
                    bcnt_d  = '0;
                    buf_d   = '{default: '0};
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_ACCEPT;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            err_q   <= 1'b0;
            buf_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            err_q   <= err_d;
            buf_q   <= buf_d;
        end
    end

    // Output block is zero except during the emit cycle.
    always_comb begin
        out_data = '0;
        if (state_q == ST_EMIT) begin
            for (int k = 0; k < RATE_WORDS; k++) begin
                out_data[RATE_BITS-1-WORD_W*k -: WORD_W] = buf_q[k];
            end
        end
    end

    assign out_en        = (state_q == ST_EMIT);
    assign out_len       = out_en ? {bcnt_q, 3'b000} : 11'd0;
    assign out_block_num = out_en ? 4'd1 : 4'd0;
    assign err           = err_q;
    assign busy          = (state_q != ST_ACCEPT) || (wcnt_q != 5'd0);

endmodule
